axi_uncache_slave: RTL
======================

Name: axi_uncache_slave

Overview:
- AXI3 slave responder that terminates the uncached-data AXI channel (ids, FIFO-less single beats, FIXED/INCR bursts) and drives a synchronous single-port SRAM.
- Used as the memory/peripheral-side model and on-chip scratchpad behind the crossbar, opposite the uncached data bridge.
- Handles one transaction at a time and arbitrates between reads and writes round-robin.

Parameters:
- BASE_ADDR, 32'h1FAF_0000, byte base of the decoded window.
- AW_WORDS, 10, log2 of SRAM depth in 32-bit words; window = 4<<AW_WORDS bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  AR channel.
- arvalid in 1, arready out 1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready in 1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2; awvalid in 1; awready out 1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1; wready out 1.
- bid/bresp/bvalid  out  4/2/1; bready in 1.
- arlock/arcache/arprot/arqos, awlock/awcache/awprot/awqos  in  2/4/3/4 each  ignored.
- sram_en  out 1; sram_we out 4; sram_addr out AW_WORDS; sram_wdata out 32; sram_rdata in 32 (valid cycle after sram_en with we=0).

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = read-first. Reset asserted mid-transaction abandons it; no response is issued afterwards.
- States: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP.
- IDLE, request present:
  - arready=1 when arvalid and (no awvalid or pointer=read).
  - awready=1 when awvalid and (no arvalid or pointer=write).
  - Never both in one cycle.
  - On handshake, latch id/addr/len/size/burst, clear beat counter, flip pointer to the other type.
  - Go to RD_REQ or WR_DATA.
- Address per beat:
  - FIXED (0): latched address every beat.
  - INCR (1): address += 1<<size after each beat; 32-bit wrap.
  - WRAP (2) / reserved (3): every beat errors.
  - In-range: BASE_ADDR <= addr < BASE_ADDR + (4<<AW_WORDS); sram_addr = (addr-BASE_ADDR)[AW_WORDS+1:2].
- Read:
  - RD_REQ: sram_en=1, we=0 (in-range and legal burst only); next state RD_WAIT.
  - RD_WAIT: capture sram_rdata (or 0 on error) into the rdata register; next state RD_RESP.
  - RD_RESP: rvalid=1; rid=latched id; rresp=2'b00, or 2'b10 on error; rlast=(cnt==len). Hold all R outputs stable until rready.
  - On handshake: last beat -> IDLE, else cnt++ and return to RD_REQ.
  - AR handshake to first rvalid = 3 cycles; beat-to-beat = 3 cycles with rready=1.
- Write:
  - WR_DATA: wready=1. On wvalid&&wready, sram_en=1, sram_we=wstrb, sram_wdata=wdata, same cycle (suppressed on error).
  - wdata is the full 32-bit lane; wstrb selects bytes; size is not used to re-align.
  - Sticky err flag sets on: out of range, illegal burst, or wlast != (cnt==len).
  - Beat with cnt==len -> WR_RESP, regardless of wlast; otherwise cnt++.
  - WR_RESP: bvalid=1, bid=latched id, bresp=err?2'b10:2'b00; on bready -> IDLE.
- wid is not checked. Simultaneous AR/AW in IDLE resolves via the pointer. AR/AW arriving while busy stall (ready=0).
- RAW ordering is guaranteed because only one transaction is in flight.

Test Plan:
- Reset, then write awaddr=BASE+8, awlen=0, wdata=32'hDEADBEEF, wstrb=4'hF, then read same address -> sram_we=4'hF at word 2, bresp=0, rdata=32'hDEADBEEF, rlast=1, rvalid exactly 3 cycles after AR handshake.
- Write wstrb=4'b0010 wdata=32'h0000AB00 over 32'h11223344 -> readback 32'h1122AB44.
- INCR read arlen=3 arsize=2 from BASE, rready toggling 1/0 -> 4 beats at words 0..3, rdata stable while stalled, rlast only on beat 4.
- FIXED write awlen=1 to BASE+4 -> both beats hit word 1, second value retained.
- Read araddr=BASE-4 and write with awburst=2 -> no sram_en, rdata=0, rresp=2'b10, bresp=2'b10.
- arvalid and awvalid high together twice after reset -> read granted first, write next; rst pulsed during RD_RESP -> rvalid drops immediately, returns to IDLE.

Source files
------------

// File: rtl/axi_uncache_slave_if.sv
// axi_uncache_slave_if: AXI3 bus carried between the uncached data bridge and the slave responder
interface axi_uncache_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_uncache_slave.sv
// axi_uncache_slave: single-transaction AXI3 slave terminating uncached traffic into a 32-bit SRAM
module axi_uncache_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1FAF_0000,
    parameter int          AW_WORDS  = 10
) (
    input  logic                clk,
    input  logic                rst,
    axi_uncache_slave_if.slave  s_axi,
    output logic                o_sram_en,
    output logic [3:0]          o_sram_we,
    output logic [AW_WORDS-1:0] o_sram_addr,
    output logic [31:0]         o_sram_wdata,
    input  logic [31:0]         i_sram_rdata
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

    localparam logic [31:0] WIN_BYTES = 32'd4 << AW_WORDS;

    state_t      r_state;
    state_t      w_next;
    logic        r_wr_turn;
    logic [3:0]  r_id;
    logic [3:0]  r_len;
    logic [3:0]  r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] w_off;
    logic        w_beat_err;
    logic        w_last_beat;
    logic        w_ar_hs;
    logic        w_aw_hs;
    logic        w_r_hs;
    logic        w_w_hs;
    logic        w_unused;

    assign w_off       = r_addr - BASE_ADDR;
    assign w_beat_err  = (w_off >= WIN_BYTES) || r_burst[1];
    assign w_last_beat = r_cnt == r_len;
    assign w_ar_hs     = s_axi.arvalid && s_axi.arready;
    assign w_aw_hs     = s_axi.awvalid && s_axi.awready;
    assign w_r_hs      = s_axi.rvalid && s_axi.rready;
    assign w_w_hs      = s_axi.wvalid && s_axi.wready;
    assign w_unused    = ^{s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                           s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.wid};

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state plus every AXI and SRAM output, decoded from the current state
    always_comb begin
        w_next         = r_state;
        s_axi.arready  = 1'b0;
        s_axi.awready  = 1'b0;
        s_axi.rvalid   = 1'b0;
        s_axi.rid      = 4'h0;
        s_axi.rdata    = 32'h0;
        s_axi.rresp    = 2'b00;
        s_axi.rlast    = 1'b0;
        s_axi.wready   = 1'b0;
        s_axi.bvalid   = 1'b0;
        s_axi.bid      = 4'h0;
        s_axi.bresp    = 2'b00;
        o_sram_en      = 1'b0;
        o_sram_we      = 4'h0;
        o_sram_addr    = '0;
        o_sram_wdata   = 32'h0;
        case (r_state)
            IDLE: begin
                s_axi.arready = !rst && s_axi.arvalid && (!s_axi.awvalid || !r_wr_turn);
                s_axi.awready = !rst && s_axi.awvalid && (!s_axi.arvalid || r_wr_turn);
                w_next = s_axi.arready ? RD_REQ : s_axi.awready ? WR_DATA : IDLE;
            end
            RD_REQ: begin
                o_sram_en   = !w_beat_err;
                o_sram_addr = w_beat_err ? '0 : w_off[AW_WORDS+1:2];
                w_next      = RD_WAIT;
            end
            RD_WAIT: w_next = RD_RESP;
            RD_RESP: begin
                s_axi.rvalid = 1'b1;
                s_axi.rid    = r_id;
                s_axi.rdata  = r_rdata;
                s_axi.rresp  = w_beat_err ? 2'b10 : 2'b00;
                s_axi.rlast  = w_last_beat;
                if (s_axi.rready)
                    w_next = w_last_beat ? IDLE : RD_REQ;
            end
            WR_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid) begin
                    o_sram_en    = !w_beat_err;
                    o_sram_we    = w_beat_err ? 4'h0 : s_axi.wstrb;
                    o_sram_addr  = w_beat_err ? '0 : w_off[AW_WORDS+1:2];
                    o_sram_wdata = w_beat_err ? 32'h0 : s_axi.wdata;
                    if (w_last_beat)
                        w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bid    = r_id;
                s_axi.bresp  = r_err ? 2'b10 : 2'b00;
                if (s_axi.bready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Transaction context: latched on the address handshake, stepped once per data beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_turn <= 1'b0;
            r_id      <= 4'h0;
            r_len     <= 4'h0;
            r_cnt     <= 4'h0;
            r_size    <= 3'h0;
            r_burst   <= 2'h0;
            r_addr    <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_id      <= s_axi.arid;
                r_addr    <= s_axi.araddr;
                r_len     <= s_axi.arlen;
                r_size    <= s_axi.arsize;
                r_burst   <= s_axi.arburst;
                r_cnt     <= 4'h0;
                r_wr_turn <= 1'b1;
            end else if (w_aw_hs) begin
                r_id      <= s_axi.awid;
                r_addr    <= s_axi.awaddr;
                r_len     <= s_axi.awlen;
                r_size    <= s_axi.awsize;
                r_burst   <= s_axi.awburst;
                r_cnt     <= 4'h0;
                r_err     <= 1'b0;
                r_wr_turn <= 1'b0;
            end
            if ((w_r_hs || w_w_hs) && !w_last_beat) begin
                r_cnt <= r_cnt + 4'h1;
                if (r_burst == 2'b01)
                    r_addr <= r_addr + (32'd1 << r_size);
            end
            if (w_w_hs)
                r_err <= r_err || w_beat_err || (s_axi.wlast != w_last_beat);
        end
    end

    // Read data register, loaded the cycle after the SRAM read strobe and held through the R stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= 32'h0;
        else if (r_state == RD_WAIT)
            r_rdata <= w_beat_err ? 32'h0 : i_sram_rdata;
    end
endmodule
